// File: rtl/sensor_tx_arbiter_pkg.sv
// Shared types and constants for the DHT11 sensor UART transmit arbiter.
// Holds the FSM state enum and the 50 MHz / 9600 baud derived defaults.
package sensor_pkg;

  localparam int N_CH_DEF       = 8;
  localparam int DW_DEF         = 16;
  localparam int CLK_HZ         = 50_000_000;
  localparam int BAUD           = 9600;
  localparam int TX_EN_HOLD_DEF = CLK_HZ / BAUD;
  localparam int TX_TIMEOUT_DEF = 2_000_000;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    SEND,
    WAIT_DONE,
    ACK
  } state_t;

endpackage

// File: rtl/sensor_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Returns the first set req at or after ptr, wrapping modulo N_CH.
module rr_pick
  import sensor_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW:0] sum;

  // Walk offsets high to low so the smallest offset wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_CH)) begin
        sum = sum - (IW+1)'(N_CH);
      end
      if (req[sum[IW-1:0]]) begin
        idx   = sum[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between sensor channels.
// Optional WAIT_DONE watchdog with timeout_err: define SENSOR_TX_TIMEOUT_EN.
module sensor_tx_arbiter
  import sensor_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DW         = DW_DEF,
`ifdef SENSOR_TX_TIMEOUT_EN
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF,
`endif
  parameter int TX_EN_HOLD = TX_EN_HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*DW-1:0]      data_bus,
  input  logic                    tx_done,
  output logic [DW-1:0]           tx_data,
  output logic                    tx_en,
  output logic [N_CH-1:0]         ack,
  output logic [$clog2(N_CH)-1:0] grant_idx,
`ifdef SENSOR_TX_TIMEOUT_EN
  output logic                    timeout_err,
`endif
  output logic                    busy
);

  localparam int IW = $clog2(N_CH);
  localparam int HW = $clog2(TX_EN_HOLD + 1);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   grant_n;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [DW-1:0]   data_n;
  logic            en_n;
  logic [HW-1:0]   cnt, cnt_n;
  logic [N_CH-1:0] ack_n;
  logic            pend, pend_n;
  logic            s1, s2, s3;
  logic            done_rise;

`ifdef SENSOR_TX_TIMEOUT_EN
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic          terr_n;
`endif

  rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // s3 is the previous synchronized level, giving a clean edge detect.
  assign done_rise = s2 & ~s3;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_idx;
    data_n  = tx_data;
    en_n    = tx_en;
    cnt_n   = cnt;
    ack_n   = '0;
    pend_n  = pend;
`ifdef SENSOR_TX_TIMEOUT_EN
    tcnt_n  = '0;
    terr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        pend_n = 1'b0;
        if (|req) state_n = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          grant_n = pick_idx;
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        data_n  = data_bus[grant_idx*DW +: DW];
        en_n    = 1'b1;
        cnt_n   = HW'(TX_EN_HOLD - 1);
        state_n = SEND;
      end
      SEND: begin
        // An early completion is remembered for WAIT_DONE.
        if (done_rise) pend_n = 1'b1;
        if (cnt == '0) begin
          en_n    = 1'b0;
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
`ifdef SENSOR_TX_TIMEOUT_EN
        tcnt_n = tcnt + 1'b1;
`endif
        if (done_rise || pend) begin
          ack_n[grant_idx] = 1'b1;
          pend_n           = 1'b0;
          state_n          = ACK;
        end
`ifdef SENSOR_TX_TIMEOUT_EN
        else if (tcnt == TW'(TX_TIMEOUT - 1)) begin
          ack_n[grant_idx] = 1'b1;
          terr_n           = 1'b1;
          state_n          = ACK;
        end
`endif
      end
      ACK: begin
        ptr_n   = (grant_idx == IW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      tx_data   <= '0;
      tx_en     <= 1'b0;
      cnt       <= '0;
      ack       <= '0;
      pend      <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= grant_n;
      tx_data   <= data_n;
      tx_en     <= en_n;
      cnt       <= cnt_n;
      ack       <= ack_n;
      pend      <= pend_n;
      s1        <= tx_done;
      s2        <= s1;
      s3        <= s2;
    end
  end

`ifdef SENSOR_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt        <= tcnt_n;
      timeout_err <= terr_n;
    end
  end
`endif

endmodule

// File: doc/sensor_tx_arbiter.md
Name: sensor_tx_arbiter

Overview:
- Round-robin scheduler sharing the single 16-bit UART transmit path between the 8 DHT11 controller channels.
- Takes each channel's ready flag and 16-bit result word, grants one channel at a time and drives the UART transmitter enable/data.
- Waits for transmit completion from the baud-clock domain, then pulses the channel's buffer-used acknowledge.
- Sits between the controlDHT11 instances and UART_tx, in place of the ad-hoc scheduling path.

Parameters:
- N_CH, 8, number of requesting sensor channels (2..16).
- DW, 16, width of each channel's result word.
- TX_EN_HOLD, 5208, clk cycles tx_en is held high so the baud-clock transmitter samples it (≥ one baud period at 50 MHz / 9600).
- TX_TIMEOUT, 2_000_000, clk cycles allowed for tx_done before abort (used only with the optional feature).

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CH  per-channel ready flag (bufferPronto); level, held until acked.
- data_bus  in  N_CH*DW  channel i word at [i*DW +: DW].
- tx_done  in  1  transmit-complete from UART_tx (baud-clock domain, level or pulse).
- tx_data  out  DW  word presented to UART_tx.
- tx_en  out  1  transmit request to UART_tx.
- ack  out  N_CH  one-hot, one-cycle buffer-used pulse to the served channel.
- grant_idx  out  $clog2(N_CH)  index of channel currently/last served.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx_data=0, tx_en=0, ack=0, grant_idx=0, busy=0, rr pointer=0, sync flops=0.
- tx_done passes through a 2-flop synchronizer. Completion is its rising edge (done_rise) after synchronization.
- States:
  - IDLE: if |req, go to ARB; else stay.
  - ARB: select the first set req at or after ptr, wrapping modulo N_CH. Register grant_idx, then go to LOAD. If req has dropped to 0, return to IDLE.
  - LOAD: tx_data <= data_bus[grant_idx*DW +: DW]. Data is latched once and stays stable until the next LOAD. Go to SEND.
  - SEND: tx_en=1 for exactly TX_EN_HOLD cycles (down-counter), then tx_en=0, go to WAIT_DONE.
  - WAIT_DONE: wait for done_rise, then go to ACK. A done_rise that occurs during SEND is latched and honoured on entry.
  - ACK: ack[grant_idx]=1 for one cycle, ptr <= grant_idx+1 (wraps to 0 after N_CH-1), go to IDLE.
- Latency: req assertion to tx_en high is 3 clk cycles (IDLE→ARB→LOAD→SEND).
- Fairness: a channel re-asserting req immediately waits for every other pending channel before being served again. Worst-case wait is N_CH-1 transfers.
- Boundaries:
  - A single requester is served repeatedly; ptr wrap is correct.
  - All req high: service order is ptr, ptr+1, … modulo N_CH.
  - A req drop during SEND/WAIT_DONE does not abort; the transfer completes and ack still pulses.
  - New req arrivals mid-transfer are only considered at the next ARB.
  - tx_done already high (stuck) at entry to SEND does not produce done_rise; the FSM waits for a new edge.
  - rst_n low mid-transfer returns to reset values immediately. tx_en drops asynchronously.
- ack is never asserted on more than one bit; grant_idx < N_CH always.

Optional Feature:
- Macro: SENSOR_TX_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in WAIT_DONE. On reaching TX_TIMEOUT it goes to ACK anyway (frees the channel) and pulses a 1-bit output timeout_err for one cycle.
  - timeout_err resets to 0.
- Without the macro: no counter, no timeout_err port, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package sensor_pkg: state enum (IDLE, ARB, LOAD, SEND, WAIT_DONE, ACK), DW, N_CH defaults, and the 50 MHz/9600 baud-derived TX_EN_HOLD constant.
- One natural sub-module: rr_pick, a combinational round-robin priority selector (req, ptr → idx, valid), reusable by the command dispatcher.

Test Plan:
- Reset mid-SEND (rst_n low at cycle 100 of tx_en) → tx_en=0 same cycle, state IDLE, ack=0, grant_idx=0.
- Single request: req=8'b0000_0100, ch2 word 16'h1A2B, tx_done pulse 10 cycles after tx_en falls → tx_en high exactly TX_EN_HOLD cycles starting 3 cycles after req; tx_data=16'h1A2B; ack=8'b0000_0100 for one cycle 3 cycles after the done pulse (sync + edge + ACK).
- All eight req high, ptr=0, each ack'd channel re-asserting immediately → serve order 0,1,…,7,0 and no channel served twice within 8 transfers.
- ptr=6, req=8'b0100_0001 → ch6 served, then ch0 (wrap), then ch6.
- tx_done held high before SEND and never toggled → no ack. With SENSOR_TX_TIMEOUT_EN and TX_TIMEOUT=1000: ack and timeout_err pulse 1000 cycles after WAIT_DONE entry.
- req dropped during WAIT_DONE → transfer completes and ack still pulses for the original grant_idx.
